iir_coeff_ctrl: RTL and testbench
=================================

# iir_coeff_ctrl

Coefficient configuration controller for the IIR filter datapath. It accepts a stream of feed-forward (b) and feedback (a) coefficients over a valid/ready word interface into a shadow bank. It then commits the whole set atomically to the packed coefficient buses on a sample boundary, so the filter never computes with a partially updated coefficient set. It sits between the acquisition control/register interface and the filter's `packed_a_coeffs` / `packed_b_coeffs` inputs.

## Interface
Parameters:
- `M`, 2: filter order. Number of a coefficients is M; number of b coefficients is N = M+1.
- `COEFF_WIDTH`, 8: width of one signed coefficient.
- `RESET_B0`, 8'sd64: reset value of b[0]. Every other coefficient resets to 0, so the reset filter is a pure gain.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  coefficient word valid.
- `wr_ready`  out  1  controller can accept a word.
- `wr_data`  in  COEFF_WIDTH  signed coefficient word.
- `wr_last`  in  1  marks the final word of a set.
- `cancel`  in  1  discards any shadow load in progress or armed.
- `sample_strobe`  in  1  filter sample-boundary pulse, one cycle wide.
- `packed_b_coeffs`  out  COEFF_WIDTH*(M+1)  active b set; b[t] occupies bits [COEFF_WIDTH*t +: COEFF_WIDTH].
- `packed_a_coeffs`  out  COEFF_WIDTH*M  active a set, packed the same way.
- `armed`  out  1  a complete shadow set is waiting to be committed.
- `swap_done`  out  1  one-cycle pulse in the cycle after the active set changes.
- `err`  out  1  one-cycle pulse on a framing error.
- `filter_rst_n`  out  1  active-low reset for the filter's delay line. Only driven when `IIR_COEFF_CTRL_FLUSH_EN` is defined; see Configuration.

## Operation
- **Set format:** a set is K = 2M+1 words, sent in the order b[0]..b[M], then a[0]..a[M-1].
- **Transfers:** a transfer occurs when `wr_valid && wr_ready` is sampled high at a rising edge of `clk`.
- **Word counter:** a word counter runs from 0 to K-1 and selects the shadow register to write.
- **States:**
  - IDLE: `wr_ready`=1. A transfer writes shadow[0] and moves to LOAD. If that transfer also has `wr_last`=1 and K≠1, it is an error.
  - LOAD: `wr_ready`=1. Each transfer writes shadow[count] and increments the counter.
    - A transfer with count=K-1 and `wr_last`=1 moves to ARMED.
    - A transfer with `wr_last`=1 and count<K-1 is an error.
    - A transfer with count=K-1 and `wr_last`=0 is an error.
  - ARMED: `wr_ready`=0 and `armed`=1. When `sample_strobe`=1, the active set is loaded from shadow at that edge. The next state is IDLE, or FLUSH if the macro is defined.
  - FLUSH (macro only): see Configuration.
- **Error handling:** an error pulses `err`, discards the shadow set, clears the counter and returns to IDLE. The active set is never touched.
- **Cancel:** `cancel`=1 in LOAD or ARMED returns to IDLE and clears the counter, with no `err` and no swap.
- **Simultaneous events:**
  - `cancel` has priority over `sample_strobe` and over a transfer in the same cycle.
  - In the cycle that enters ARMED, `sample_strobe` is ignored. Commit needs a strobe sampled while already in ARMED.
- **Arithmetic:** coefficients are stored verbatim, with no sign conversion or saturation.

## Timing
- **Reset:** with `rst`=1 at an edge, the block goes to IDLE next cycle with:
  - counter 0;
  - shadow registers 0;
  - b[0]=`RESET_B0`, all other coefficients 0;
  - `armed`=0, `swap_done`=0, `err`=0, `wr_ready`=1, `filter_rst_n`=1.
- **Reset mid-load or mid-flush:** reset aborts the operation completely and also reloads the reset coefficient set.
- **Output registering:** all outputs are registered, with no combinational path from inputs to outputs. Exception: `wr_ready` is decoded from state only.
- **Commit latency:** `sample_strobe` is sampled in ARMED at edge E. The packed buses change at E, and `swap_done` is high in the cycle following E.
- **Load throughput:** one word per cycle, so a back-to-back load of K words reaches ARMED K edges after the first transfer.
- **Error latency:** `err` is high in the cycle after the offending transfer.

## Configuration
- **Macro:** `IIR_COEFF_CTRL_FLUSH_EN`.
- **Defined:**
  - After a commit, the block enters FLUSH and drives `filter_rst_n`=0 for N cycles. This clears the filter delay line so stale history is not run through the new coefficients.
  - `wr_ready`=0 during FLUSH, and `cancel` has no effect in FLUSH.
  - The block then returns to IDLE and `filter_rst_n` goes back to 1.
- **Undefined:** no FLUSH state exists, `filter_rst_n` is tied to 1, and a commit goes straight to IDLE.

## Structure
- **Shared package `iir_pkg`:**
  - `iir_coeff_t`, a signed COEFF_WIDTH coefficient type;
  - the state enumeration (IDLE, LOAD, ARMED, FLUSH);
  - the word-count function K(M)=2M+1;
  - the packing-offset helper used by both this block and the filter.
- **Sub-module `iir_coeff_bank`:** a natural split. It is a K-entry register bank with an indexed write port and a whole-bank parallel copy to active registers. It is instantiated once, and the FSM and counter stay in `iir_coeff_ctrl`.

## Test plan
- **Reset values:** reset, then check `packed_b_coeffs`=0x000040 and `packed_a_coeffs`=0x0000 (M=2), with `wr_ready`=1 and `armed`=0.
- **Nominal load and commit:** load 5 words 0x10,0x20,0x30,0x0A,0xF6 with `wr_last` on the 5th, so `armed`=1 and the outputs are unchanged. Pulse `sample_strobe`: the outputs become b=0x302010 and a=0xF60A, and `swap_done` pulses next cycle.
- **Early `wr_last`:** `wr_last` on word 3 gives `err`=1 for one cycle and returns to IDLE with the outputs unchanged. A subsequent correct set then commits normally.
- **Missing `wr_last`:** 5 words with no `wr_last` gives an `err` pulse after word 5. `sample_strobe` afterwards causes no swap.
- **Cancel priority:** `cancel` and `sample_strobe` asserted in the same cycle while ARMED give IDLE with no `swap_done` and unchanged outputs.
- **Flush (macro defined):** a commit gives `filter_rst_n`=0 for exactly 3 cycles and `wr_ready`=0 during that window. A `rst` asserted in cycle 2 of the flush restores the reset coefficients and `filter_rst_n`=1.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared IIR types and helpers: coefficient type, controller states, set length, packing offsets.
package iir_pkg;

  localparam int COEFF_WIDTH_DEF = 8;

  typedef logic signed [COEFF_WIDTH_DEF-1:0] iir_coeff_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_FLUSH = 2'd3
  } iir_state_e;

  // Words per coefficient set: b[0..M] then a[0..M-1].
  function automatic int unsigned iir_num_words(input int unsigned m);
    return 2 * m + 1;
  endfunction

  // LSB of coefficient idx inside a packed coefficient bus.
  function automatic int unsigned iir_coeff_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// K-entry shadow bank with indexed write, bulk clear, and atomic copy to the active set.
module iir_coeff_bank
  import iir_pkg::*;
#(
  parameter int                            M           = 2,
  parameter int                            COEFF_WIDTH = 8,
  parameter logic signed [COEFF_WIDTH-1:0] RESET_B0    = 8'sd64,
  parameter int                            K           = iir_num_words(M),
  parameter int                            IW          = (K > 1) ? $clog2(K) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [IW-1:0]                i_wr_idx,
  input  logic [COEFF_WIDTH-1:0]       i_wr_data,
  input  logic                         i_clr,
  input  logic                         i_commit,
  output logic [COEFF_WIDTH*(M+1)-1:0] o_packed_b,
  output logic [COEFF_WIDTH*M-1:0]     o_packed_a
);

  logic [COEFF_WIDTH-1:0] r_shadow [K];
  logic [COEFF_WIDTH-1:0] r_active [K];

  for (genvar t = 0; t < K; t++) begin : g_ent
    localparam logic [COEFF_WIDTH-1:0] RST_VAL = (t == 0) ? RESET_B0 : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_shadow[t] <= '0;
        r_active[t] <= RST_VAL;
      end else begin
        // Clear wins over a same-cycle write so a discarded set leaves nothing behind.
        if (i_clr)
          r_shadow[t] <= '0;
        else if (i_wr_en && (i_wr_idx == IW'(t)))
          r_shadow[t] <= i_wr_data;
        if (i_commit)
          r_active[t] <= r_shadow[t];
      end
    end

    if (t <= M) begin : g_b
      assign o_packed_b[iir_coeff_lsb(t, COEFF_WIDTH) +: COEFF_WIDTH] = r_active[t];
    end else begin : g_a
      assign o_packed_a[iir_coeff_lsb(t - M - 1, COEFF_WIDTH) +: COEFF_WIDTH] = r_active[t];
    end
  end

endmodule

// File: rtl/iir_coeff_ctrl.sv
// IIR coefficient controller: framed shadow load, atomic commit on sample_strobe.
// Optional post-commit delay-line flush enabled by IIR_COEFF_CTRL_FLUSH_EN.
module iir_coeff_ctrl
  import iir_pkg::*;
#(
  parameter int                            M           = 2,
  parameter int                            COEFF_WIDTH = 8,
  parameter logic signed [COEFF_WIDTH-1:0] RESET_B0    = 8'sd64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  input  logic                         wr_last,
  input  logic                         cancel,
  input  logic                         sample_strobe,
  output logic [COEFF_WIDTH*(M+1)-1:0] packed_b_coeffs,
  output logic [COEFF_WIDTH*M-1:0]     packed_a_coeffs,
  output logic                         armed,
  output logic                         swap_done,
  output logic                         err,
  output logic                         filter_rst_n
);

  localparam int              K        = iir_num_words(M);
  localparam int              N        = M + 1;
  localparam int              IW       = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(K - 1);

  iir_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_cnt, w_cnt_nxt;
  logic          w_xfer, w_wr_en, w_clr, w_commit, w_err;
  logic          r_armed, r_swap_done, r_err;

`ifdef IIR_COEFF_CTRL_FLUSH_EN
  localparam int FW = $clog2(N + 1);
  logic [FW-1:0] r_flush_cnt;
  logic          r_filter_rst_n;
`endif

  assign wr_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_xfer   = wr_valid && wr_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_clr       = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end else if (w_xfer) begin
          w_wr_en = 1'b1;
          // Framing is good only when wr_last coincides exactly with the final word.
          if ((r_cnt == LAST_IDX) != wr_last) begin
            w_err       = 1'b1;
            w_clr       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else if (wr_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ARMED;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_ARMED: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (sample_strobe) begin
          w_commit = 1'b1;
`ifdef IIR_COEFF_CTRL_FLUSH_EN
          w_state_nxt = ST_FLUSH;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef IIR_COEFF_CTRL_FLUSH_EN
      ST_FLUSH: begin
        if (r_flush_cnt == '0)
          w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_swap_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_armed     <= (w_state_nxt == ST_ARMED);
      r_swap_done <= w_commit;
      r_err       <= w_err;
    end
  end

`ifdef IIR_COEFF_CTRL_FLUSH_EN
  // Flush holds the filter in reset for N cycles after every commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt    <= '0;
      r_filter_rst_n <= 1'b1;
    end else begin
      if (w_commit)
        r_flush_cnt <= FW'(N - 1);
      else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0))
        r_flush_cnt <= r_flush_cnt - 1'b1;
      r_filter_rst_n <= (w_state_nxt != ST_FLUSH);
    end
  end
  assign filter_rst_n = r_filter_rst_n;
`else
  assign filter_rst_n = 1'b1;
`endif

  assign armed     = r_armed;
  assign swap_done = r_swap_done;
  assign err       = r_err;

  iir_coeff_bank #(
    .M           (M),
    .COEFF_WIDTH (COEFF_WIDTH),
    .RESET_B0    (RESET_B0),
    .K           (K),
    .IW          (IW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_cnt),
    .i_wr_data  (wr_data),
    .i_clr      (w_clr),
    .i_commit   (w_commit),
    .o_packed_b (packed_b_coeffs),
    .o_packed_a (packed_a_coeffs)
  );

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed bench for iir_coeff_ctrl (M=2, 8-bit coefficients); flush checks when IIR_COEFF_CTRL_FLUSH_EN is set.
module tb_iir_coeff_ctrl;
  import iir_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_last = 1'b0;
  logic        cancel = 1'b0;
  logic        sample_strobe = 1'b0;
  iir_coeff_t  wr_data = '0;
  logic        wr_ready, armed, swap_done, err, filter_rst_n;
  logic [23:0] packed_b_coeffs;
  logic [15:0] packed_a_coeffs;

  int errors = 0;
  int checks = 0;

  iir_coeff_ctrl #(.M(2), .COEFF_WIDTH(8), .RESET_B0(8'sd64)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .wr_last         (wr_last),
    .cancel          (cancel),
    .sample_strobe   (sample_strobe),
    .packed_b_coeffs (packed_b_coeffs),
    .packed_a_coeffs (packed_a_coeffs),
    .armed           (armed),
    .swap_done       (swap_done),
    .err             (err),
    .filter_rst_n    (filter_rst_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send n back-to-back words (word i in bits 8i); wr_last on last_pos, optional strobe on word 4.
  task automatic load_words(input logic [39:0] words, input int n, input int last_pos,
                            input bit strobe_last);
    for (int i = 0; i < n; i++) begin
      wr_valid      = 1'b1;
      wr_data       = words[8*i +: 8];
      wr_last       = (i == last_pos);
      sample_strobe = strobe_last && (i == 4);
      step();
    end
    wr_valid = 1'b0; wr_last = 1'b0; sample_strobe = 1'b0; wr_data = '0;
  endtask

  task automatic commit();
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && wr_ready !== 1'b1; i++) step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: wr_ready got %b want 1 within 20 cycles", wr_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs} !== {24'h000040, 16'h0000}) begin
      errors++;
      $display("FAIL reset_coeffs: got b=%h a=%h want b=000040 a=0000", packed_b_coeffs, packed_a_coeffs);
    end
    checks++;
    if ({wr_ready, armed, swap_done, err, filter_rst_n} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_flags: got rdy/arm/swap/err/frst=%b want 10001",
               {wr_ready, armed, swap_done, err, filter_rst_n});
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    // strobe with the final word must not commit: ARMED is not yet the current state
    load_words({8'hF6, 8'h0A, 8'h30, 8'h20, 8'h10}, 5, 4, 1'b1);
    checks++;
    if ({armed, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL nominal_armed: got armed/rdy=%b want 10", {armed, wr_ready});
    end
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs, swap_done} !== {24'h000040, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL nominal_pre_commit: got b=%h a=%h swap=%b want b=000040 a=0000 swap=0",
               packed_b_coeffs, packed_a_coeffs, swap_done);
    end
    commit();
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs} !== {24'h302010, 16'hF60A}) begin
      errors++;
      $display("FAIL nominal_commit: got b=%h a=%h want b=302010 a=f60a", packed_b_coeffs, packed_a_coeffs);
    end
    checks++;
    if ({swap_done, armed} !== 2'b10) begin
      errors++;
      $display("FAIL nominal_swap_pulse: got swap/armed=%b want 10", {swap_done, armed});
    end
    step();
    checks++;
    if (swap_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_swap_clear: got %b want 0", swap_done);
    end
    wait_idle();
  endtask

  task automatic test_early_last();
    load_words({8'h00, 8'h00, 8'h33, 8'h22, 8'h11}, 3, 2, 1'b0);
    checks++;
    if ({err, armed, wr_ready} !== 3'b101) begin
      errors++;
      $display("FAIL early_last_err: got err/armed/rdy=%b want 101", {err, armed, wr_ready});
    end
    step();
    checks++;
    if ({err, packed_b_coeffs, packed_a_coeffs} !== {1'b0, 24'h302010, 16'hF60A}) begin
      errors++;
      $display("FAIL early_last_after: got err=%b b=%h a=%h want err=0 b=302010 a=f60a",
               err, packed_b_coeffs, packed_a_coeffs);
    end
    load_words({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 5, 4, 1'b0);
    commit();
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs, swap_done} !== {24'h030201, 16'h0504, 1'b1}) begin
      errors++;
      $display("FAIL early_last_recover: got b=%h a=%h swap=%b want b=030201 a=0504 swap=1",
               packed_b_coeffs, packed_a_coeffs, swap_done);
    end
    wait_idle();
  endtask

  task automatic test_missing_last();
    load_words({8'h03, 8'h02, 8'h01, 8'h80, 8'h7F}, 5, -1, 1'b0);
    checks++;
    if ({err, armed} !== 2'b10) begin
      errors++;
      $display("FAIL missing_last_err: got err/armed=%b want 10", {err, armed});
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL missing_last_err_clear: got %b want 0", err);
    end
    commit();
    checks++;
    if ({swap_done, packed_b_coeffs, packed_a_coeffs} !== {1'b0, 24'h030201, 16'h0504}) begin
      errors++;
      $display("FAIL missing_last_no_swap: got swap=%b b=%h a=%h want swap=0 b=030201 a=0504",
               swap_done, packed_b_coeffs, packed_a_coeffs);
    end
  endtask

  task automatic test_cancel();
    load_words({8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA}, 5, 4, 1'b0);
    cancel = 1'b1; sample_strobe = 1'b1;
    step();
    cancel = 1'b0; sample_strobe = 1'b0;
    checks++;
    if ({armed, swap_done, err, wr_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL cancel_priority_flags: got armed/swap/err/rdy=%b want 0001",
               {armed, swap_done, err, wr_ready});
    end
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs} !== {24'h030201, 16'h0504}) begin
      errors++;
      $display("FAIL cancel_priority_coeffs: got b=%h a=%h want b=030201 a=0504",
               packed_b_coeffs, packed_a_coeffs);
    end
    step();
    checks++;
    if (swap_done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_no_late_swap: got %b want 0", swap_done);
    end
  endtask

  task automatic test_back_to_back();
    // cancel mid-load also wins over a same-cycle transfer; counter must restart at b[0]
    load_words({8'h00, 8'h00, 8'h00, 8'h66, 8'h55}, 2, -1, 1'b0);
    wr_valid = 1'b1; wr_data = 8'h77; cancel = 1'b1;
    step();
    wr_valid = 1'b0; cancel = 1'b0;
    checks++;
    if ({armed, err, wr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL cancel_midload: got armed/err/rdy=%b want 001", {armed, err, wr_ready});
    end
    load_words({8'h09, 8'h08, 8'h07, 8'h06, 8'h05}, 5, 4, 1'b0);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL b2b_armed_after_k: got %b want 1", armed);
    end
    commit();
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs} !== {24'h070605, 16'h0908}) begin
      errors++;
      $display("FAIL b2b_commit: got b=%h a=%h want b=070605 a=0908", packed_b_coeffs, packed_a_coeffs);
    end
    wait_idle();
  endtask

  task automatic test_reset_midload();
    load_words({8'h00, 8'h00, 8'h00, 8'h34, 8'h12}, 2, -1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs, armed, wr_ready} !== {24'h000040, 16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL reset_midload: got b=%h a=%h armed=%b rdy=%b want b=000040 a=0000 armed=0 rdy=1",
               packed_b_coeffs, packed_a_coeffs, armed, wr_ready);
    end
    load_words({8'hA9, 8'h87, 8'h65, 8'h43, 8'h21}, 5, 4, 1'b0);
    commit();
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs} !== {24'h654321, 16'hA987}) begin
      errors++;
      $display("FAIL reset_midload_reload: got b=%h a=%h want b=654321 a=a987",
               packed_b_coeffs, packed_a_coeffs);
    end
    wait_idle();
  endtask

`ifdef IIR_COEFF_CTRL_FLUSH_EN
  task automatic test_flush();
    load_words({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 5, 4, 1'b0);
    commit();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({filter_rst_n, wr_ready} !== 2'b00) begin
        errors++;
        $display("FAIL flush_cycle%0d: got frst/rdy=%b want 00", c + 1, {filter_rst_n, wr_ready});
      end
      step();
    end
    checks++;
    if ({filter_rst_n, wr_ready} !== 2'b11) begin
      errors++;
      $display("FAIL flush_end: got frst/rdy=%b want 11", {filter_rst_n, wr_ready});
    end
    load_words({8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B}, 5, 4, 1'b0);
    commit();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({packed_b_coeffs, packed_a_coeffs, filter_rst_n, wr_ready} !== {24'h000040, 16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL flush_reset: got b=%h a=%h frst=%b rdy=%b want b=000040 a=0000 frst=1 rdy=1",
               packed_b_coeffs, packed_a_coeffs, filter_rst_n, wr_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_early_last();
    test_missing_last();
    test_cancel();
    test_back_to_back();
    test_reset_midload();
`ifdef IIR_COEFF_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
